// File: rtl/hbm_rd_unpack_pkg.sv
// Shared definitions for the HBM read-unpack path: beat/word widths,
// AR burst size encodings and the unpacker FSM state type.
package hbm_rd_unpack_pkg;

    localparam int HBM_DATA_WIDTH = 256;
    localparam int OUT_WIDTH      = 64;

    localparam logic [2:0] ARSIZE_256 = 3'b101;
    localparam logic [2:0] ARSIZE_512 = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // AXI ARSIZE encoding for a supported beat width; unsupported widths map to 0
    function automatic logic [2:0] arsize_for(input int width);
        logic [2:0] size_v;
        case (width)
            256:     size_v = ARSIZE_256;
            512:     size_v = ARSIZE_512;
            default: size_v = 3'b000;
        endcase
        return size_v;
    endfunction

endpackage

// File: rtl/hbm_rd_unpack_fifo.sv
// First-word fall-through FIFO holding full HBM read beats.
// The head entry is visible on dout whenever the FIFO is not empty.
module hbm_fwft_fifo
    import hbm_rd_unpack_pkg::*;
#(
    parameter int  DEPTH      = 32,
    parameter int  DATA_WIDTH = 256,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty_s;

    // Beat storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/hbm_rd_unpack.sv
// HBM read-beat unpacker: buffers wide read beats and serialises each one
// into RATIO output words (LSB slice first) over a valid/ready handshake,
// while policing the per-job beat count and reporting overflow/stray beats.
module hbm_rd_unpack
    import hbm_rd_unpack_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int DEPTH      = 32,
    parameter int AF_MARGIN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           num_beats,
    input  logic                  dn_vld,
    input  logic [DATA_WIDTH-1:0] dn_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [OUT_WIDTH-1:0]  out_dat,
    output logic                  out_last,
    output logic                  almost_full,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err,
    output logic                  stray_err
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    state_e                state_r;
    logic [31:0]           num_beats_r;
    logic [31:0]           acc_cnt_r;
    logic [31:0]           out_cnt_r;
    logic [SW-1:0]         sub_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  ovf_r;
    logic                  stray_r;
    logic                  af_r;

    logic [DATA_WIDTH-1:0] fifo_dout_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    logic                  out_vld_s;
    logic                  sub_last_s;
    logic                  last_beat_s;
    logic                  out_last_s;
    logic                  start_acc_s;
    logic                  hs_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  ovf_s;
    logic                  stray_s;
    logic                  final_s;
    logic [CW-1:0]         count_next_s;
    logic [OUT_WIDTH-1:0]  words_s [RATIO];

    hbm_fwft_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (dn_dat),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Split the head beat into its output word slices, index 0 = LSBs
    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign words_s[g] = fifo_dout_s[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign out_vld_s   = ~fifo_empty_s;
    assign sub_last_s  = (sub_r == SW'(RATIO - 1));
    assign last_beat_s = (out_cnt_r == (num_beats_r - 32'd1));
    assign out_last_s  = out_vld_s & sub_last_s & last_beat_s;

    // Decide push/drop for the incoming beat, the pop and the next FIFO occupancy
    always_comb begin
        push_s       = 1'b0;
        ovf_s        = 1'b0;
        stray_s      = 1'b0;
        start_acc_s  = start & (state_r == ST_IDLE);
        hs_s         = out_vld_s & out_rdy;
        pop_s        = hs_s & sub_last_s;
        final_s      = hs_s & out_last_s & (state_r == ST_RUN);
        count_next_s = fifo_count_s;
        if (dn_vld) begin
            if ((state_r == ST_RUN) && (acc_cnt_r < num_beats_r)) begin
                if (fifo_full_s) begin
                    ovf_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                stray_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + CW'(1);
            2'b01:   count_next_s = fifo_count_s - CW'(1);
            default: count_next_s = fifo_count_s;
        endcase
    end

    // Job FSM, beat/word counters, sub-word index, status and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            num_beats_r <= 32'd0;
            acc_cnt_r   <= 32'd0;
            out_cnt_r   <= 32'd0;
            sub_r       <= {SW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            stray_r     <= 1'b0;
            af_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_beats_r <= num_beats;
                        acc_cnt_r   <= 32'd0;
                        out_cnt_r   <= 32'd0;
                        sub_r       <= {SW{1'b0}};
                        if (num_beats == 32'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (push_s) begin
                        acc_cnt_r <= acc_cnt_r + 32'd1;
                    end
                    if (pop_s) begin
                        sub_r     <= {SW{1'b0}};
                        out_cnt_r <= out_cnt_r + 32'd1;
                    end else if (hs_s) begin
                        sub_r <= sub_r + SW'(1);
                    end
                    if (final_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            // A new job clears the flags, but an error in the same cycle is never lost
            ovf_r   <= ovf_s   | (ovf_r   & ~start_acc_s);
            stray_r <= stray_s | (stray_r & ~start_acc_s);
            af_r    <= (count_next_s >= CW'(DEPTH - AF_MARGIN));
        end
    end

    assign out_vld     = out_vld_s;
    assign out_dat     = out_vld_s ? words_s[sub_r] : {OUT_WIDTH{1'b0}};
    assign out_last    = out_last_s;
    assign almost_full = af_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign ovf_err     = ovf_r;
    assign stray_err   = stray_r;

endmodule

// File: tb/tb_hbm_rd_unpack.sv
// Self-checking bench for hbm_rd_unpack: randomized beats checked every cycle
// against a word-queue reference model of the unpacker.
module tb_hbm_rd_unpack;

    localparam int DW    = 256;
    localparam int OW    = 64;
    localparam int DEPTH = 32;
    localparam int AFM   = 8;
    localparam int R     = DW / OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   num_beats;
    logic          dn_vld;
    logic [DW-1:0] dn_dat;
    logic          out_rdy;
    logic          out_vld;
    logic [OW-1:0] out_dat;
    logic          out_last;
    logic          almost_full;
    logic          busy;
    logic          done;
    logic          ovf_err;
    logic          stray_err;

    always #5 clk = ~clk;

    hbm_rd_unpack #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_beats   (num_beats),
        .dn_vld      (dn_vld),
        .dn_dat      (dn_dat),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_dat     (out_dat),
        .out_last    (out_last),
        .almost_full (almost_full),
        .busy        (busy),
        .done        (done),
        .ovf_err     (ovf_err),
        .stray_err   (stray_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending output words in order, plus job bookkeeping
    logic [OW-1:0] q[$];
    bit            m_run;
    bit            m_done;
    bit            m_ovf;
    bit            m_stray;
    int unsigned   m_num;
    int unsigned   m_acc;
    longint        m_popped;

    int            hs_cnt;
    int            done_cnt;
    bit            prev_stall;
    logic [OW-1:0] prev_dat;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_beats();
        return (q.size() + R - 1) / R;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_run = 0; m_done = 0; m_ovf = 0; m_stray = 0;
        m_num = 0; m_acc = 0; m_popped = 0;
        prev_stall = 0;
    endtask

    task automatic compare_outputs();
        bit vld;
        vld = (q.size() > 0);
        check_eq("out_vld", out_vld, vld);
        if (vld) check_eq("out_dat", out_dat, q[0]);
        check_eq("out_last", out_last, vld && (m_popped == longint'(m_num) * R - 1));
        check_eq("almost_full", almost_full, m_beats() >= DEPTH - AFM);
        check_eq("busy", busy, m_run);
        check_eq("done", done, m_done);
        check_eq("ovf_err", ovf_err, m_ovf);
        check_eq("stray_err", stray_err, m_stray);
        if (prev_stall) check_eq("stall_stable", out_dat, prev_dat);
        prev_stall = out_vld && !out_rdy;
        prev_dat   = out_dat;
        if (out_vld && out_rdy) hs_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic model_update();
        bit vld, hs, old_run, set_ovf, set_stray, nxt_done;
        int beats;
        vld = (q.size() > 0);
        hs = vld && out_rdy;
        beats = m_beats();
        old_run = m_run;
        set_ovf = 0; set_stray = 0; nxt_done = 0;
        if (dn_vld) begin
            if (old_run && m_acc < m_num) begin
                if (beats >= DEPTH) set_ovf = 1;
                else begin
                    for (int i = 0; i < R; i++) q.push_back(dn_dat[i*OW +: OW]);
                    m_acc++;
                end
            end else set_stray = 1;
        end
        if (hs) begin
            void'(q.pop_front());
            m_popped++;
            if (old_run && m_popped == longint'(m_num) * R) begin
                m_run = 0;
                nxt_done = 1;
            end
        end
        if (start && !old_run) begin
            m_ovf = 0; m_stray = 0; m_acc = 0; m_popped = 0;
            m_num = num_beats;
            if (num_beats == 0) nxt_done = 1;
            else m_run = 1;
        end
        if (set_ovf) m_ovf = 1;
        if (set_stray) m_stray = 1;
        m_done = nxt_done;
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send_start(input int unsigned n);
        start = 1'b1;
        num_beats = n;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat();
        dn_vld = 1'b1;
        dn_dat = rand_beat();
        step();
        dn_vld = 1'b0;
    endtask

    task automatic run_until_idle(input int cap);
        dn_vld = 1'b0;
        for (int i = 0; i < cap && (m_run || q.size() > 0 || m_done); i++) step();
        check_eq("drain_busy", busy, 1'b0);
        check_eq("drain_vld", out_vld, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vld"}, out_vld, 1'b0);
        check_eq({tag, "_dat"}, out_dat, 64'd0);
        check_eq({tag, "_last"}, out_last, 1'b0);
        check_eq({tag, "_af"}, almost_full, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_ovf"}, ovf_err, 1'b0);
        check_eq({tag, "_stray"}, stray_err, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int hs0, dn0;
        rst_n = 1'b0; start = 1'b0; num_beats = 32'd0;
        dn_vld = 1'b0; dn_dat = '0; out_rdy = 1'b0;
        hs_cnt = 0; done_cnt = 0;
        model_reset();
        #2;
        check_all_zero("reset");
        apply_reset();

        // 1: four back-to-back beats, consumer always ready
        hs0 = hs_cnt; dn0 = done_cnt;
        out_rdy = 1'b1;
        send_start(4);
        for (int i = 0; i < 4; i++) send_beat();
        run_until_idle(60);
        check_eq("t1_words", hs_cnt - hs0, 16);
        check_eq("t1_done", done_cnt - dn0, 1);

        // 2: fill to full with the consumer stalled, then overflow
        out_rdy = 1'b0;
        send_start(40);
        for (int i = 0; i < 32; i++) begin
            send_beat();
            check_eq("t2_af_rise", almost_full, (i + 1) >= (DEPTH - AFM));
        end
        send_beat();
        check_eq("t2_ovf", ovf_err, 1'b1);
        check_eq("t2_af_full", almost_full, 1'b1);
        out_rdy = 1'b1;
        for (int i = 0; i < 40; i++) step();
        for (int i = 0; i < 8; i++) send_beat();
        run_until_idle(200);

        // 3: random consumer stalls, producer throttled on occupancy
        hs0 = hs_cnt;
        send_start(100);
        for (int i = 0; i < 4000 && (m_run || m_done); i++) begin
            out_rdy = 1'($urandom_range(0, 1));
            dn_vld = (m_run && m_acc < 100 && m_beats() < DEPTH - AFM && $urandom_range(0, 1) == 1);
            dn_dat = rand_beat();
            step();
        end
        dn_vld = 1'b0;
        out_rdy = 1'b1;
        run_until_idle(20);
        check_eq("t3_words", hs_cnt - hs0, 400);
        check_eq("t3_no_ovf", ovf_err, 1'b0);

        // 4: stray beats while idle and beyond num_beats
        send_beat();
        check_eq("t4_stray_idle", stray_err, 1'b1);
        hs0 = hs_cnt;
        send_start(4);
        for (int i = 0; i < 5; i++) send_beat();
        run_until_idle(60);
        check_eq("t4_stray_extra", stray_err, 1'b1);
        check_eq("t4_words", hs_cnt - hs0, 16);

        // 5: zero-length job
        hs0 = hs_cnt; dn0 = done_cnt;
        send_start(0);
        step();
        step();
        check_eq("t5_done", done_cnt - dn0, 1);
        check_eq("t5_words", hs_cnt - hs0, 0);

        // 6: reset in the middle of a 20-beat job
        send_start(20);
        for (int i = 0; i < 20; i++) send_beat();
        for (int i = 0; i < 200 && m_popped < 40; i++) step();
        dn0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_no_done", done_cnt - dn0, 0);
        hs0 = hs_cnt; dn0 = done_cnt;
        send_start(2);
        for (int i = 0; i < 2; i++) send_beat();
        run_until_idle(40);
        check_eq("t6_words", hs_cnt - hs0, 8);
        check_eq("t6_done", done_cnt - dn0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
